// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS checker and any matching generator:
// the checker state encoding and the parity feedback function.
package lfsr_pkg;

  // Widest LFSR the feedback function accepts.
  localparam int MAX_N = 64;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Feedback bit: XOR of every history bit selected by the tap mask.
  // Narrower registers are zero-extended by the caller.
  function automatic logic parity_fb(input logic [MAX_N-1:0] hist,
                                     input logic [MAX_N-1:0] taps);
    return ^(hist & taps);
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// PRBS stream checker: hunts for a nonzero seed, verifies a run of correct
// predictions, then free-runs its own reference and counts bit errors.
//
// Handshake: valid_i qualifies data_i. There is no backpressure; every bit
// presented with valid_i=1 is consumed on that clock edge, and with
// valid_i=0 all state holds.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int            N               = 8,
  parameter logic [N-1:0]  TAPS            = N'(8'b00000011),
  parameter bit            VARIABLE_CONFIG = 1'b0,
  parameter int            LOCK_COUNT      = 16,
  parameter int            WINDOW          = 64,
  parameter int            LOSS_THRESHOLD  = 8,
  parameter int            ERR_W           = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic             data_i,
  input  logic             load_config_i,
  input  logic [N-1:0]     taps_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             error_o,
  output logic [ERR_W-1:0] err_count_o,
  output state_t           state_o
);

  localparam int FILL_W  = $clog2(N + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_THRESHOLD + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(N - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THRESHOLD - 1);

  state_t              state, state_n;
  logic [N-1:0]        h, h_n;
  logic [N-1:0]        tap_reg, tap_sel;
  logic [FILL_W-1:0]   fill, fill_n;
  logic [MATCH_W-1:0]  match, match_n;
  logic [WIN_W-1:0]    win, win_n;
  logic [WERR_W-1:0]   win_err, win_err_n;
  logic [ERR_W-1:0]    err_count_n;
  logic                err_pulse_n;
  logic                pred;
  logic                mismatch;

  assign tap_sel  = VARIABLE_CONFIG ? tap_reg : TAPS;
  assign pred     = parity_fb(MAX_N'(h), MAX_N'(tap_sel));
  assign mismatch = data_i ^ pred;
  assign state_o  = state;

  // Next-state, history and counter updates; load beats clear beats data.
  always_comb begin
    state_n     = state;
    h_n         = h;
    fill_n      = fill;
    match_n     = match;
    win_n       = win;
    win_err_n   = win_err;
    err_count_n = err_count_o;
    err_pulse_n = 1'b0;
    if (load_config_i) begin
      state_n     = HUNT;
      fill_n      = '0;
      match_n     = '0;
      win_n       = '0;
      win_err_n   = '0;
      err_count_n = '0;
    end else begin
      if (clear_i) err_count_n = '0;
      if (valid_i) begin
        unique case (state)
          HUNT: begin
            h_n = {data_i, h[N-1:1]};
            if (fill == FILL_LAST) begin
              // A full history of zeros can never predict a PRBS; refill.
              fill_n = '0;
              if (h_n != '0) begin
                state_n = VERIFY;
                match_n = '0;
              end
            end else begin
              fill_n = fill + 1'b1;
            end
          end
          VERIFY: begin
            h_n = {data_i, h[N-1:1]};
            if (mismatch) begin
              state_n = HUNT;
              fill_n  = '0;
              match_n = '0;
            end else if (match == MATCH_LAST) begin
              state_n   = LOCKED;
              match_n   = '0;
              win_n     = '0;
              win_err_n = '0;
            end else begin
              match_n = match + 1'b1;
            end
          end
          LOCKED: begin
            // Reference free-runs on its own prediction so a line error
            // never propagates into later predictions.
            h_n   = {pred, h[N-1:1]};
            win_n = (win == WIN_LAST) ? '0 : win + 1'b1;
            if (mismatch) begin
              err_pulse_n = 1'b1;
              if (!clear_i && (err_count_o != '1)) err_count_n = err_count_o + 1'b1;
            end
            if (mismatch && (win_err == WERR_LAST)) begin
              state_n   = HUNT;
              fill_n    = '0;
              match_n   = '0;
              win_n     = '0;
              win_err_n = '0;
            end else if (win == WIN_LAST) begin
              win_err_n = '0;
            end else if (mismatch) begin
              win_err_n = win_err + 1'b1;
            end
          end
          default: state_n = HUNT;
        endcase
      end
    end
  end

  // State, counters and registered outputs; reset clears asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= HUNT;
      h           <= '0;
      tap_reg     <= TAPS;
      fill        <= '0;
      match       <= '0;
      win         <= '0;
      win_err     <= '0;
      err_count_o <= '0;
      locked_o    <= 1'b0;
      error_o     <= 1'b0;
    end else begin
      state       <= state_n;
      h           <= h_n;
      fill        <= fill_n;
      match       <= match_n;
      win         <= win_n;
      win_err     <= win_err_n;
      err_count_o <= err_count_n;
      locked_o    <= (state_n == LOCKED);
      error_o     <= err_pulse_n;
      if (load_config_i && VARIABLE_CONFIG) tap_reg <= taps_i;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed lock/loss/clear/reset scenarios plus a
// randomized phase, all scored against a bit-stream reference model.
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam int         N        = 8;
  localparam logic [7:0] TB_TAPS  = 8'b00000011;
  localparam int         LOCK_CNT = 16;
  localparam int         WIN      = 64;
  localparam int         THR      = 8;
  localparam int         CNT_MAX  = 65535;

  localparam int M_HUNT   = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic        clk_i;
  logic        reset_i;
  logic        valid_i;
  logic        data_i;
  logic        load_config_i;
  logic [7:0]  taps_i;
  logic        clear_i;
  logic        locked_o;
  logic        error_o;
  logic [15:0] err_count_o;
  state_t      state_o;

  lfsr_checker dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .load_config_i (load_config_i),
    .taps_i        (taps_i),
    .clear_i       (clear_i),
    .locked_o      (locked_o),
    .error_o       (error_o),
    .err_count_o   (err_count_o),
    .state_o       (state_o)
  );

  // Clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream source: last N emitted bits, oldest first; new bit = XOR of taps.
  bit gen_q[$];

  function automatic bit gen_next();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (TB_TAPS[i]) p ^= gen_q[i];
    gen_q.push_back(p);
    void'(gen_q.pop_front());
    return p;
  endfunction

  // Reference model: checker behaviour in terms of bits seen and counts.
  bit m_hist[$];
  int m_mode, m_fill, m_match, m_wpos, m_werr, m_count;
  bit m_locked, m_error;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < N; i++) m_hist.push_back(1'b0);
    m_mode = M_HUNT; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_count = 0;
    m_locked = 1'b0; m_error = 1'b0;
  endfunction

  function automatic bit model_predict();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (TB_TAPS[i]) p ^= m_hist[i];
    return p;
  endfunction

  function automatic void model_shift(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endfunction

  function automatic void model_step(input bit v, input bit d, input bit ld, input bit clr);
    bit p, any_one;
    m_error = 1'b0;
    if (ld) begin
      m_mode = M_HUNT; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0; m_count = 0;
    end else begin
      if (clr) m_count = 0;
      if (v) begin
        p = model_predict();
        if (m_mode == M_HUNT) begin
          model_shift(d);
          m_fill++;
          if (m_fill == N) begin
            m_fill = 0;
            any_one = 1'b0;
            foreach (m_hist[i]) any_one |= m_hist[i];
            if (any_one) begin m_mode = M_VERIFY; m_match = 0; end
          end
        end else if (m_mode == M_VERIFY) begin
          model_shift(d);
          if (d != p) begin
            m_mode = M_HUNT; m_fill = 0; m_match = 0;
          end else begin
            m_match++;
            if (m_match == LOCK_CNT) begin
              m_mode = M_LOCKED; m_match = 0; m_wpos = 0; m_werr = 0;
            end
          end
        end else begin
          model_shift(p);
          m_wpos++;
          if (d != p) begin
            m_error = 1'b1;
            if (!clr && m_count < CNT_MAX) m_count++;
            m_werr++;
          end
          if (d != p && m_werr >= THR) begin
            m_mode = M_HUNT; m_fill = 0; m_match = 0; m_wpos = 0; m_werr = 0;
          end else if (m_wpos == WIN) begin
            m_wpos = 0; m_werr = 0;
          end
        end
      end
    end
    m_locked = (m_mode == M_LOCKED);
  endfunction

  // Driver: apply one cycle of inputs, advance the model, score outputs.
  task automatic step(input bit v, input bit d, input bit ld, input bit clr);
    valid_i       = v;
    data_i        = d;
    load_config_i = ld;
    clear_i       = clr;
    taps_i        = 8'($urandom_range(0, 255));
    @(posedge clk_i);
    model_step(v, d, ld, clr);
    #1;
    check("locked", 32'(locked_o), 32'(m_locked));
    check("error", 32'(error_o), 32'(m_error));
    check("count", 32'(err_count_o), 32'(m_count));
  endtask

  int  lock_at, nvalid, pulses, guard;
  bit  any_locked, lk7, lk8;
  logic [7:0] seed;

  initial begin
    seed = 8'h01;
    for (int i = 0; i < N; i++) gen_q.push_back(seed[i]);
    reset_i = 1'b1; valid_i = 1'b0; data_i = 1'b0;
    load_config_i = 1'b0; clear_i = 1'b0; taps_i = '0;
    model_reset();
    #2;
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_count", 32'(err_count_o), 32'd0);
    check("rst_state", 32'(state_o), 32'(HUNT));
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // Clean stream, valid every cycle.
    lock_at = 0;
    for (int k = 1; k <= 1000; k++) begin
      step(1'b1, gen_next(), 1'b0, 1'b0);
      if (locked_o && lock_at == 0) lock_at = k;
    end
    check("clean_lock_bit", 32'(lock_at), 32'd24);
    check("clean_count", 32'(err_count_o), 32'd0);

    // Single inverted bit while locked.
    pulses = 0;
    step(1'b1, gen_next() ^ 1'b1, 1'b0, 1'b0);
    if (error_o) pulses++;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, gen_next(), 1'b0, 1'b0);
      if (error_o) pulses++;
    end
    check("single_pulses", 32'(pulses), 32'd1);
    check("single_count", 32'(err_count_o), 32'd1);
    check("single_locked", 32'(locked_o), 32'd1);

    // Clear, then eight errors inside one window: lose lock, then relock.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clear_count", 32'(err_count_o), 32'd0);
    guard = 0;
    while (m_wpos != 0 && guard < 2 * WIN) begin
      step(1'b1, gen_next(), 1'b0, 1'b0);
      guard++;
    end
    lk7 = 1'b0; lk8 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, gen_next() ^ 1'b1, 1'b0, 1'b0);
      if (k == 7) lk7 = locked_o;
      if (k == 8) lk8 = locked_o;
    end
    check("loss_locked_at7", 32'(lk7), 32'd1);
    check("loss_locked_at8", 32'(lk8), 32'd0);
    check("loss_count", 32'(err_count_o), 32'd8);
    lock_at = 0;
    for (int k = 1; k <= 100 && lock_at == 0; k++) begin
      step(1'b1, gen_next(), 1'b0, 1'b0);
      if (locked_o) lock_at = k;
    end
    check("relock_bits", 32'(lock_at), 32'd24);

    // Error coinciding with clear: clear wins.
    step(1'b1, gen_next() ^ 1'b1, 1'b0, 1'b0);
    check("pre_clear_count", 32'(err_count_o), 32'd9);
    step(1'b1, gen_next() ^ 1'b1, 1'b0, 1'b1);
    check("clear_vs_err", 32'(err_count_o), 32'd0);

    // Reset mid-lock drops locked_o before any clock edge.
    step(1'b1, gen_next(), 1'b0, 1'b0);
    check("pre_reset_locked", 32'(locked_o), 32'd1);
    #3 reset_i = 1'b1;
    #1;
    check("async_reset_locked", 32'(locked_o), 32'd0);
    check("async_reset_count", 32'(err_count_o), 32'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    model_reset();

    // All-zero stream never locks.
    any_locked = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      any_locked |= locked_o;
    end
    check("zeros_never_locked", 32'(any_locked), 32'd0);
    check("zeros_state", 32'(state_o), 32'(HUNT));

    // Restart search, then valid on alternate cycles.
    step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    lock_at = 0; nvalid = 0;
    for (int k = 0; k < 120 && lock_at == 0; k++) begin
      if (k % 2 == 0) begin
        step(1'b1, gen_next(), 1'b0, 1'b0);
        nvalid++;
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      if (locked_o) lock_at = nvalid;
    end
    check("halfrate_lock_bits", 32'(lock_at), 32'd24);

    // Randomized traffic: gaps, sparse errors, clears and reloads.
    for (int k = 0; k < 3000; k++) begin
      bit v, inv, clr, ld;
      v   = ($urandom_range(0, 3) != 0);
      inv = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 499) == 0);
      if (v) step(1'b1, gen_next() ^ inv, ld, clr);
      else   step(1'b0, 1'($urandom_range(0, 1)), ld, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
